// File: rtl/div_pkg.sv
// Shared types and constants for the iterative Execute-stage divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CYCLES = 35;
    localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, then try to subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] dvs_ext;
    logic           fits;

    always_comb begin
        rem_sh  = {rem_i, quo_i[WIDTH-1]};
        dvs_ext = {1'b0, divisor_i};
        fits    = (rem_sh >= dvs_ext);
        rem_o   = rem_sh[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], 1'b0};
        // A fitting trial always leaves a remainder below the divisor, so the low WIDTH bits suffice.
        if (fits) begin
            rem_o = WIDTH'(rem_sh - dvs_ext);
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider for the Execute stage; holds the pipeline via alu_stallE
// until quotient (div_lo) and remainder (div_hi) are ready.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_enE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] src_aE,
    input  logic [WIDTH-1:0] src_bE,
    input  logic             mem_stall,
    input  logic             cancel,
    output logic             alu_stallE,
    output logic             div_ready,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_nx),
        .quo_o     (quo_nx)
    );

    // Stall is combinational so the hazard unit freezes E in the very cycle the DIV arrives.
    assign alu_stallE = ~cancel & (((state_q == IDLE) & div_enE) |
                                   (state_q == PREP) | (state_q == CALC) | (state_q == FIX));
    assign div_ready  = ready_q;
    assign div_hi     = hi_q;
    assign div_lo     = lo_q;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_raw_d = a_raw_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        ready_d = ready_q;
        a_neg   = div_signedE & src_aE[WIDTH-1];
        b_neg   = div_signedE & src_bE[WIDTH-1];
        q_fix   = q_neg_q ? (WIDTH'(0) - quo_q) : quo_q;
        r_fix   = r_neg_q ? (WIDTH'(0) - rem_q) : rem_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (div_enE) begin
                    state_d = PREP;
                    a_raw_d = src_aE;
                    dvd_d   = a_neg ? (WIDTH'(0) - src_aE) : src_aE;
                    dvs_d   = b_neg ? (WIDTH'(0) - src_bE) : src_bE;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (src_bE == '0);
                end
            end
            PREP: begin
                rem_d   = '0;
                quo_d   = dvd_q;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Signed overflow (MIN / -1) falls out of the WIDTH-bit negate naturally.
                if (dz_q) begin
                    lo_d = WIDTH'(DIV0_LO);
                    hi_d = a_raw_q;
                end else begin
                    lo_d = q_fix;
                    hi_d = r_fix;
                end
                ready_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!mem_stall) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // An exception flush abandons the operation without touching the result registers.
        if (cancel) begin
            state_d = IDLE;
            ready_d = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_raw_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_raw_q <= a_raw_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed divides, pipeline stall/cancel/reset timing.
module tb_div_iter;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        div_enE;
    logic        div_signedE;
    logic [31:0] src_aE;
    logic [31:0] src_bE;
    logic        mem_stall;
    logic        cancel;
    logic        alu_stallE;
    logic        div_ready;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic        prev_ready = 1'b0;

    div_iter #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_enE     (div_enE),
        .div_signedE (div_signedE),
        .src_aE      (src_aE),
        .src_bE      (src_bE),
        .mem_stall   (mem_stall),
        .cancel      (cancel),
        .alu_stallE  (alu_stallE),
        .div_ready   (div_ready),
        .div_hi      (div_hi),
        .div_lo      (div_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every new result presentation pops one expected {hi,lo}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && div_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: hi %08h lo %08h with nothing pending", div_hi, div_lo);
            end else begin
                e = exp_q.pop_front();
                chk("result_hi", div_hi, e[63:32]);
                chk("result_lo", div_lo, e[31:0]);
            end
        end
        prev_ready = div_ready;
    end

    // Drives one DIV from cycle T (task entry) and checks stall/ready every cycle.
    // ms_at/can_at/rst_at are cycle offsets from T, negative when unused.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input int ms_at, input int ms_len, input int can_at, input int rst_at);
        int c  = 0;
        int ab = -1;
        bit leave;
        if (can_at < 0 && rst_at < 0) exp_q.push_back({ehi, elo});
        forever begin
            div_enE     = (ab < 0);
            div_signedE = sgn;
            src_aE      = (c == 0) ? a : $urandom;
            src_bE      = (c == 0) ? b : $urandom;
            mem_stall   = (ms_at >= 0 && c >= ms_at && c < ms_at + ms_len);
            cancel      = (c == can_at);
            rst         = (c == rst_at);
            #1;
            if (ab >= 0) begin
                chk("abort_stall", 32'(alu_stallE), 32'd0);
                chk("abort_ready", 32'(div_ready), 32'd0);
                if (rst_at >= 0) begin
                    chk("rst_hi", div_hi, 32'd0);
                    chk("rst_lo", div_lo, 32'd0);
                end
                @(posedge clk); #1;
                break;
            end
            chk("stall", 32'(alu_stallE), 32'((c < 35 && c != can_at) ? 1 : 0));
            chk("ready", 32'(div_ready), 32'((c >= 35) ? 1 : 0));
            leave = (c >= 35) && !mem_stall;
            if (c == can_at || c == rst_at) ab = c;
            @(posedge clk); #1;
            c++;
            if (leave) break;
        end
        cancel    = 1'b0;
        rst       = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic idle_cycle();
        div_enE   = 1'b0;
        mem_stall = 1'b0;
        cancel    = 1'b0;
        #1;
        chk("idle_stall", 32'(alu_stallE), 32'd0);
        chk("idle_ready", 32'(div_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst         = 1'b1;
        div_enE     = 1'b0;
        div_signedE = 1'b0;
        src_aE      = '0;
        src_bE      = '0;
        mem_stall   = 1'b0;
        cancel      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_stall", 32'(alu_stallE), 32'd0);
        chk("reset_ready", 32'(div_ready), 32'd0);
        chk("reset_hi", div_hi, 32'd0);
        chk("reset_lo", div_lo, 32'd0);
        @(posedge clk); #1;

        // DIVU 100/7, then signed -7/2 back-to-back
        run_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, -1, 0, -1, -1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 0, -1, -1);
        idle_cycle();
        // Signed overflow MIN / -1
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, -1, 0, -1, -1);
        idle_cycle();
        // DIVU with top bit set must not be treated as negative
        run_div(32'h8000_0000, 32'd3, 1'b0, 32'd2, 32'h2AAA_AAAA, -1, 0, -1, -1);
        idle_cycle();
        // Signed divide by zero
        run_div(32'hFFFF_FFF6, 32'd0, 1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFFF, -1, 0, -1, -1);
        idle_cycle();
        // Signed 100 / -7 with a 5-cycle mem_stall from T+33
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1, 32'd2, 32'hFFFF_FFF2, 33, 5, -1, -1);
        idle_cycle();
        idle_cycle();
        // Cancel at T+10, new DIVU at T+12
        run_div(32'd12345, 32'd5, 1'b0, 32'd0, 32'd0, -1, 0, 10, -1);
        run_div(32'hDEAD_BEEF, 32'h10, 1'b0, 32'hF, 32'h0DEA_DBEE, -1, 0, -1, -1);
        idle_cycle();
        // Reset at T+20, then DIVU 0xFFFFFFFF / 1
        run_div(32'd50, 32'd3, 1'b0, 32'd0, 32'd0, -1, 0, -1, 20);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, -1, 0, -1, -1);
        idle_cycle();
        idle_cycle();

        chk("pending_results", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
